my_pe_pv2: RTL and testbench

//   Parametrised successor of the pv1 processing element: local weight RAM plus a signed MAC.

---
 rtl/my_pe_pv2.sv | 176 +++++++++++++++++
 tb/tb_my_pe_pv2.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/my_pe_pv2.sv
// -----------------------------------------------------------------------------
// my_pe_pv2 - processing element: local weight RAM feeding a signed MAC.
//
// The array controller first preloads weights through we/din/addr. It then
// streams activations on ain with valid. Each issued MAC multiplies ain by the
// weight at mem[addr]. The product is added to, or subtracted from, the
// accumulator two clock edges later, and dvalid pulses for one cycle.
//
// Ports
//   aclk      in   1            clock, rising edge
//   aresetn   in   1            asynchronous active-low reset
//   ain       in   DATA_W       activation operand (signed)
//   din       in   DATA_W       RAM write data
//   addr      in   L_RAM_SIZE   RAM address for write or MAC read
//   we        in   1            RAM write enable (blocks a MAC issue)
//   valid     in   1            issue one MAC with ain and mem[addr]
//   subtract  in   1            1: acc -= product, 0: acc += product
//   clear     in   1            synchronous accumulator / overflow clear
//   dvalid    out  1            one-cycle pulse per completed MAC
//   dout      out  DATA_W       registered RAM read data (write-first)
//   pcout     out  ACC_W        accumulator (signed)
//   ovf       out  1            sticky signed-overflow flag
// -----------------------------------------------------------------------------
module my_pe_pv2 #(
    parameter int L_RAM_SIZE = 4,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 48
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_W-1:0]     ain,
    input  logic [DATA_W-1:0]     din,
    input  logic [L_RAM_SIZE-1:0] addr,
    input  logic                  we,
    input  logic                  valid,
    input  logic                  subtract,
    input  logic                  clear,
    output logic                  dvalid,
    output logic [DATA_W-1:0]     dout,
    output logic [ACC_W-1:0]      pcout,
    output logic                  ovf
);

    localparam int DEPTH = 1 << L_RAM_SIZE;
    localparam int P_W   = 2 * DATA_W;

    // Signed overflow of a +/- b: an add overflows when the operand signs
    // match and the result sign differs. A subtract overflows when the
    // operand signs differ and the result sign differs from a.
    function automatic logic ovf_detect(input logic a_msb,
                                        input logic b_msb,
                                        input logic r_msb,
                                        input logic sub);
        logic sign_cond;
        if (sub) begin
            sign_cond = (a_msb != b_msb);
        end else begin
            sign_cond = (a_msb == b_msb);
        end
        return sign_cond && (r_msb != a_msb);
    endfunction

    logic [DATA_W-1:0]        mem_r [DEPTH];
    logic [DATA_W-1:0]        rd_data_s;
    logic [DATA_W-1:0]        fwd_data_s;
    logic                     issue_s;

    logic [DATA_W-1:0]        a1_r;
    logic [DATA_W-1:0]        w1_r;
    logic                     sub1_r;
    logic                     v1_r;

    logic signed [P_W-1:0]    prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W-1:0]         result_s;
    logic [ACC_W-1:0]         fresh_s;
    logic                     ovf_event_s;

    logic [DATA_W-1:0]        dout_r;
    logic [ACC_W-1:0]         pcout_r;
    logic                     dvalid_r;
    logic                     ovf_r;

    // RAM write port. Contents are deliberately not reset.
    always_ff @(posedge aclk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    // Read mux with same-edge write forwarding so that dout is write-first.
    // A write blocks issue, so the forward path never feeds stage 1.
    always_comb begin
        rd_data_s  = mem_r[addr];
        fwd_data_s = rd_data_s;
        if (we) begin
            fwd_data_s = din;
        end else begin
            fwd_data_s = rd_data_s;
        end
        issue_s = valid & ~we;
    end

    // Registered RAM read port.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dout_r <= {DATA_W{1'b0}};
        end else begin
            dout_r <= fwd_data_s;
        end
    end

    // Stage 1 operand capture. v1_r is cleared by reset so that in-flight
    // MACs are dropped.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1_r   <= 1'b0;
            a1_r   <= {DATA_W{1'b0}};
            w1_r   <= {DATA_W{1'b0}};
            sub1_r <= 1'b0;
        end else begin
            v1_r <= issue_s;
            if (issue_s) begin
                a1_r   <= ain;
                w1_r   <= rd_data_s;
                sub1_r <= subtract;
            end
        end
    end

    // Stage 2 datapath: signed product, sign extension, accumulate or
    // subtract, and overflow detection.
    always_comb begin
        prod_s     = $signed(a1_r) * $signed(w1_r);
        prod_ext_s = ACC_W'(prod_s);
        if (sub1_r) begin
            result_s = pcout_r - prod_ext_s;
            fresh_s  = -prod_ext_s;
        end else begin
            result_s = pcout_r + prod_ext_s;
            fresh_s  = prod_ext_s;
        end
        ovf_event_s = ovf_detect(pcout_r[ACC_W-1], prod_ext_s[ACC_W-1],
                                 result_s[ACC_W-1], sub1_r);
    end

    // Accumulator, sticky overflow and completion pulse. When clear and a
    // stage-2 update land on the same edge, the new sum starts with this
    // product.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pcout_r  <= {ACC_W{1'b0}};
            ovf_r    <= 1'b0;
            dvalid_r <= 1'b0;
        end else begin
            dvalid_r <= v1_r;
            if (clear) begin
                ovf_r <= 1'b0;
                if (v1_r) begin
                    pcout_r <= fresh_s;
                end else begin
                    pcout_r <= {ACC_W{1'b0}};
                end
            end else if (v1_r) begin
                pcout_r <= result_s;
                ovf_r   <= ovf_r | ovf_event_s;
            end
        end
    end

    assign dout   = dout_r;
    assign pcout  = pcout_r;
    assign dvalid = dvalid_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_my_pe_pv2.sv
// -----------------------------------------------------------------------------
// tb_my_pe_pv2 - directed testbench for my_pe_pv2.
//
// It instantiates a 48-bit accumulator instance and a 16-bit accumulator
// instance. Both are driven by the same stimulus. The 16-bit instance exposes
// the wraparound and overflow behaviour.
// -----------------------------------------------------------------------------
module tb_my_pe_pv2;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  ain;
    logic [7:0]  din;
    logic [3:0]  addr;
    logic        we;
    logic        valid;
    logic        subtract;
    logic        clear;

    logic        dvalid;
    logic [7:0]  dout;
    logic [47:0] pcout;
    logic        ovf;

    logic        dvalid16;
    logic [7:0]  dout16;
    logic [15:0] pcout16;
    logic        ovf16;

    int n_vec;
    int n_err;

    my_pe_pv2 #(.L_RAM_SIZE(4), .DATA_W(8), .ACC_W(48)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .ain(ain), .din(din), .addr(addr),
        .we(we), .valid(valid), .subtract(subtract), .clear(clear),
        .dvalid(dvalid), .dout(dout), .pcout(pcout), .ovf(ovf)
    );

    my_pe_pv2 #(.L_RAM_SIZE(4), .DATA_W(8), .ACC_W(16)) u_dut16 (
        .aclk(aclk), .aresetn(aresetn), .ain(ain), .din(din), .addr(addr),
        .we(we), .valid(valid), .subtract(subtract), .clear(clear),
        .dvalid(dvalid16), .dout(dout16), .pcout(pcout16), .ovf(ovf16)
    );

    // 100 MHz clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Compare one observed value with its expected value.
    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns past it.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    int dv_cnt;
    int first_idx;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        ain      = 8'd5;
        din      = 8'd0;
        addr     = 4'd0;
        we       = 1'b0;
        valid    = 1'b1;
        subtract = 1'b0;
        clear    = 1'b0;
        aresetn  = 1'b0;

        // Reset held with valid asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_pcout", 64'(pcout), 64'd0);
            check_val("rst_dvalid", 64'(dvalid), 64'd0);
            check_val("rst_dout", 64'(dout), 64'd0);
            check_val("rst_ovf", 64'(ovf), 64'd0);
        end
        valid   = 1'b0;
        aresetn = 1'b1;
        tick();
        check_val("post_rst_dvalid", 64'(dvalid), 64'd0);

        // Load mem[k] = k+1.
        we = 1'b1;
        for (int k = 0; k < 16; k++) begin
            addr = 4'(k);
            din  = 8'(k + 1);
            tick();
        end
        we   = 1'b0;
        addr = 4'd4;
        tick();
        check_val("dout_rd4", 64'(dout), 64'd5);
        check_val("load_pcout", 64'(pcout), 64'd0);

        // 16 back-to-back MACs, ain=2.
        dv_cnt    = 0;
        first_idx = -1;
        ain       = 8'd2;
        subtract  = 1'b0;
        for (int i = 0; i < 18; i++) begin
            valid = (i < 16);
            addr  = 4'(i % 16);
            tick();
            if (dvalid) begin
                dv_cnt = dv_cnt + 1;
                if (first_idx < 0) first_idx = i;
            end
        end
        valid = 1'b0;
        check_val("stream_dv_cnt", 64'(dv_cnt), 64'd16);
        check_val("stream_first_dv", 64'(first_idx), 64'd1);
        check_val("stream_pcout", 64'(pcout), 64'd272);
        check_val("stream_pcout16", 64'(pcout16), 64'd272);

        // Clear coincident with stage-2 update of product 2*3=6.
        addr  = 4'd2;
        ain   = 8'd2;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("clr_mac_pcout", 64'(pcout), 64'd6);
        check_val("clr_mac_dvalid", 64'(dvalid), 64'd1);
        check_val("clr_mac_ovf", 64'(ovf), 64'd0);
        // Next MAC accumulates on 6: 2*mem[1]=4 -> 10.
        addr  = 4'd1;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        check_val("after_clr_pcout", 64'(pcout), 64'd10);

        // Subtract: mem[3]=-2, ain=5 -> 10 - (-10) = 20.
        we   = 1'b1;
        addr = 4'd3;
        din  = 8'hFE;
        tick();
        we       = 1'b0;
        valid    = 1'b1;
        ain      = 8'h05;
        subtract = 1'b1;
        tick();
        valid    = 1'b0;
        subtract = 1'b0;
        check_val("sub_stage1_dvalid", 64'(dvalid), 64'd0);
        tick();
        check_val("sub_pcout", 64'(pcout), 64'd20);
        check_val("sub_ovf", 64'(ovf), 64'd0);
        check_val("sub_dout", 64'(dout), 64'hFE);

        // Read-after-write: mem[5]=7, ain=3 -> +21 = 41.
        we   = 1'b1;
        addr = 4'd5;
        din  = 8'd7;
        tick();
        we    = 1'b0;
        valid = 1'b1;
        ain   = 8'd3;
        tick();
        valid = 1'b0;
        tick();
        check_val("raw_pcout", 64'(pcout), 64'd41);
        // valid && we: write happens, no MAC.
        valid = 1'b1;
        we    = 1'b1;
        din   = 8'd9;
        tick();
        valid = 1'b0;
        we    = 1'b0;
        check_val("we_prio_dout", 64'(dout), 64'd9);
        tick();
        check_val("we_prio_dv1", 64'(dvalid), 64'd0);
        tick();
        check_val("we_prio_dv2", 64'(dvalid), 64'd0);
        check_val("we_prio_pcout", 64'(pcout), 64'd41);

        // Clear alone.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("clear_pcout", 64'(pcout), 64'd0);

        // Overflow on 16-bit accumulator: (-128)*(-128)=16384, three adds.
        we   = 1'b1;
        addr = 4'd0;
        din  = 8'h80;
        tick();
        we    = 1'b0;
        valid = 1'b1;
        ain   = 8'h80;
        tick();
        tick();
        check_val("ovf16_p1", 64'(pcout16), 64'h4000);
        check_val("ovf16_f1", 64'(ovf16), 64'd0);
        tick();
        valid = 1'b0;
        check_val("ovf16_p2", 64'(pcout16), 64'h8000);
        check_val("ovf16_f2", 64'(ovf16), 64'd1);
        tick();
        check_val("ovf16_p3", 64'(pcout16), 64'hC000);
        check_val("ovf16_sticky", 64'(ovf16), 64'd1);
        check_val("ovf48_p3", 64'(pcout), 64'd49152);
        check_val("ovf48_f3", 64'(ovf), 64'd0);
        tick();
        tick();
        check_val("ovf16_hold", 64'(ovf16), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("ovf16_clr_p", 64'(pcout16), 64'd0);
        check_val("ovf16_clr_f", 64'(ovf16), 64'd0);

        // Reset mid-operation discards the in-flight MAC.
        addr  = 4'd5;
        ain   = 8'd3;
        valid = 1'b1;
        tick();
        valid   = 1'b0;
        aresetn = 1'b0;
        #2;
        check_val("midrst_pcout", 64'(pcout), 64'd0);
        tick();
        aresetn = 1'b1;
        tick();
        check_val("midrst_dv1", 64'(dvalid), 64'd0);
        tick();
        check_val("midrst_dv2", 64'(dvalid), 64'd0);
        check_val("midrst_pcout2", 64'(pcout), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
